// File: rtl/exception_ctrl_if.sv
// Core-side bundle for the exception sequencer: decoder status, PC, redirects and MRS state.
interface exception_ctrl_if #(
   parameter int unsigned N = 64
);
   logic [3:0]   EStatus;
   logic         ERet;
   logic         ExtIRQ;
   logic [N-1:0] PC;
   logic         Exc;
   logic [N-1:0] ExcVector;
   logic         ERetTaken;
   logic         KillWB;
   logic         ExtIAck;
   logic [N-1:0] ELR;
   logic [3:0]   ESR;
   logic         ExcMode;
   logic         Halt;
   logic [7:0]   ExcCount;

   modport master (
      output EStatus, ERet, ExtIRQ, PC,
      input  Exc, ExcVector, ERetTaken, KillWB, ExtIAck, ELR, ESR, ExcMode, Halt, ExcCount
   );

   modport slave (
      input  EStatus, ERet, ExtIRQ, PC,
      output Exc, ExcVector, ERetTaken, KillWB, ExtIAck, ELR, ESR, ExcMode, Halt, ExcCount
   );
endinterface

// File: rtl/exception_ctrl.sv
// Exception sequencer for the single-cycle LEGv8 core: redirects to the handler vector,
// returns via ELR on ERET, and locks up on a fault taken inside the handler.
module exception_ctrl #(
   parameter int unsigned  N         = 64,
   parameter logic [N-1:0] VECTOR    = N'('hD8),
   parameter logic [3:0]   IRQ_CODE  = 4'b0001,
   parameter logic [3:0]   ERET_CODE = 4'b0100
) (
   input logic                clk,
   input logic                reset,
   exception_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {StRun, StHandler, StLockup} state_e;

   state_e       state_q, state_d;
   logic         shadow_q, shadow_d;
   logic         ack_q, ack_d;
   logic [N-1:0] elr_q, elr_d;
   logic [3:0]   esr_q, esr_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [7:0]   cnt_inc;
   logic         sync_exc, irq_req, status_fault;
   logic         exc, eret_taken, kill_wb;

   assign status_fault = (bus.EStatus != 4'd0);
   assign sync_exc     = status_fault || bus.ERet;
   assign irq_req      = bus.ExtIRQ && !shadow_q;
   assign cnt_inc      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      ack_d      = 1'b0;
      elr_d      = elr_q;
      esr_d      = esr_q;
      cnt_d      = cnt_q;
      exc        = 1'b0;
      eret_taken = 1'b0;
      kill_wb    = 1'b0;
      unique case (state_q)
         StRun: begin
            // Any RUN cycle consumes the post-ERET shadow, whether or not it traps.
            shadow_d = 1'b0;
            if (sync_exc) begin
               exc     = 1'b1;
               kill_wb = 1'b1;
               elr_d   = bus.PC;
               esr_d   = status_fault ? bus.EStatus : ERET_CODE;
               cnt_d   = cnt_inc;
               state_d = StHandler;
            end else if (irq_req) begin
               exc     = 1'b1;
               kill_wb = 1'b1;
               elr_d   = bus.PC;
               esr_d   = IRQ_CODE;
               cnt_d   = cnt_inc;
               ack_d   = 1'b1;
               state_d = StHandler;
            end
         end
         StHandler: begin
            if (status_fault) begin
               kill_wb = 1'b1;
               cnt_d   = cnt_inc;
               state_d = StLockup;
            end else if (bus.ERet) begin
               eret_taken = 1'b1;
               shadow_d   = 1'b1;
               state_d    = StRun;
            end
         end
         StLockup: kill_wb = 1'b1;
         default:  state_d = StRun;
      endcase
      // Redirects are meaningless while the core is being reset.
      if (reset) begin
         exc        = 1'b0;
         eret_taken = 1'b0;
         kill_wb    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StRun;
         shadow_q <= 1'b0;
         ack_q    <= 1'b0;
         elr_q    <= '0;
         esr_q    <= 4'd0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         ack_q    <= ack_d;
         elr_q    <= elr_d;
         esr_q    <= esr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.Exc       = exc;
   assign bus.ExcVector = VECTOR;
   assign bus.ERetTaken = eret_taken;
   assign bus.KillWB    = kill_wb;
   assign bus.ExtIAck   = ack_q;
   assign bus.ELR       = elr_q;
   assign bus.ESR       = esr_q;
   assign bus.ExcMode   = (state_q == StHandler);
   assign bus.Halt      = (state_q == StLockup);
   assign bus.ExcCount  = cnt_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: each step queues its expected outputs, which are
// popped and compared mid-cycle.
module tb_exception_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   exception_ctrl_if #(.N(64)) bus ();

   exception_ctrl #(.N(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      logic        exc, ert, kill, ack, mode, halt;
      logic [63:0] elr;
      logic [3:0]  esr;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input string f, input logic [63:0] got,
                      input logic [63:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, f, got, want);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic [3:0] es,
                       input logic er, input logic irq, input logic [63:0] pc,
                       input logic e_exc, input logic e_ert, input logic e_kill,
                       input logic e_ack, input logic e_mode, input logic e_halt,
                       input logic [63:0] e_elr, input logic [3:0] e_esr,
                       input logic [7:0] e_cnt);
      exp_t e;
      reset       = rst;
      bus.EStatus = es;
      bus.ERet    = er;
      bus.ExtIRQ  = irq;
      bus.PC      = pc;
      sb.push_back('{tag, e_exc, e_ert, e_kill, e_ack, e_mode, e_halt, e_elr, e_esr, e_cnt});
      @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, "Exc",       64'(bus.Exc),       64'(e.exc));
      chk(e.tag, "ERetTaken", 64'(bus.ERetTaken), 64'(e.ert));
      chk(e.tag, "KillWB",    64'(bus.KillWB),    64'(e.kill));
      chk(e.tag, "ExtIAck",   64'(bus.ExtIAck),   64'(e.ack));
      chk(e.tag, "ExcMode",   64'(bus.ExcMode),   64'(e.mode));
      chk(e.tag, "Halt",      64'(bus.Halt),      64'(e.halt));
      chk(e.tag, "ELR",       bus.ELR,            e.elr);
      chk(e.tag, "ESR",       64'(bus.ESR),       64'(e.esr));
      chk(e.tag, "ExcCount",  64'(bus.ExcCount),  64'(e.cnt));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

   initial begin
      logic [7:0]  c_before, c_after;
      logic [63:0] elr_prev;
      logic [3:0]  esr_prev;

      reset       = 1'b1;
      bus.EStatus = 4'd0;
      bus.ERet    = 1'b0;
      bus.ExtIRQ  = 1'b0;
      bus.PC      = 64'd0;
      @(posedge clk);
      #1;

      //    tag               rst es   er irq pc        exc ert kil ack mod hlt elr     esr cnt
      step("rst_discard",    1, 4'd2, 0, 0, 64'h40,   0, 0, 0, 0, 0, 0, 64'h0,  4'd0, 8'd0);
      chk("vector", "ExcVector", bus.ExcVector, 64'hD8);
      step("sync_fault",     0, 4'd2, 0, 0, 64'h40,   1, 0, 1, 0, 0, 0, 64'h0,  4'd0, 8'd0);
      step("handler_irq",    0, 4'd0, 0, 1, 64'hD8,   0, 0, 0, 0, 1, 0, 64'h40, 4'd2, 8'd1);
      step("handler_eret",   0, 4'd0, 1, 1, 64'hDC,   0, 1, 0, 0, 1, 0, 64'h40, 4'd2, 8'd1);
      step("shadow_insn",    0, 4'd0, 0, 1, 64'h40,   0, 0, 0, 0, 0, 0, 64'h40, 4'd2, 8'd1);
      step("irq_taken",      0, 4'd0, 0, 1, 64'h44,   1, 0, 1, 0, 0, 0, 64'h40, 4'd2, 8'd1);
      step("irq_ack",        0, 4'd0, 0, 1, 64'hD8,   0, 0, 0, 1, 1, 0, 64'h44, 4'd1, 8'd2);
      step("ack_drop",       0, 4'd0, 0, 0, 64'hDC,   0, 0, 0, 0, 1, 0, 64'h44, 4'd1, 8'd2);
      step("eret2",          0, 4'd0, 1, 0, 64'hE0,   0, 1, 0, 0, 1, 0, 64'h44, 4'd1, 8'd2);
      step("plain",          0, 4'd0, 0, 0, 64'h44,   0, 0, 0, 0, 0, 0, 64'h44, 4'd1, 8'd2);
      step("sync_vs_irq",    0, 4'd2, 0, 1, 64'h48,   1, 0, 1, 0, 0, 0, 64'h44, 4'd1, 8'd2);
      step("no_ack",         0, 4'd0, 0, 1, 64'hD8,   0, 0, 0, 0, 1, 0, 64'h48, 4'd2, 8'd3);
      step("eret3",          0, 4'd0, 1, 1, 64'hDC,   0, 1, 0, 0, 1, 0, 64'h48, 4'd2, 8'd3);
      step("shadow2",        0, 4'd0, 0, 1, 64'h48,   0, 0, 0, 0, 0, 0, 64'h48, 4'd2, 8'd3);
      step("irq_after_shd",  0, 4'd0, 0, 1, 64'h4C,   1, 0, 1, 0, 0, 0, 64'h48, 4'd2, 8'd3);
      step("ack2",           0, 4'd0, 0, 0, 64'hD8,   0, 0, 0, 1, 1, 0, 64'h4C, 4'd1, 8'd4);
      step("eret4",          0, 4'd0, 1, 0, 64'hDC,   0, 1, 0, 0, 1, 0, 64'h4C, 4'd1, 8'd4);
      step("eret_in_run",    0, 4'd0, 1, 0, 64'h80,   1, 0, 1, 0, 0, 0, 64'h4C, 4'd1, 8'd4);
      step("eret_code",      0, 4'd0, 0, 0, 64'hD8,   0, 0, 0, 0, 1, 0, 64'h80, 4'd4, 8'd5);
      step("nested_fault",   0, 4'd2, 0, 0, 64'hDC,   0, 0, 1, 0, 1, 0, 64'h80, 4'd4, 8'd5);
      step("lockup",         0, 4'd2, 1, 1, 64'hE0,   0, 0, 1, 0, 0, 1, 64'h80, 4'd4, 8'd6);
      step("reset_lockup",   1, 4'd2, 1, 1, 64'hE0,   0, 0, 0, 0, 0, 1, 64'h80, 4'd4, 8'd6);
      step("post_reset",     0, 4'd0, 0, 0, 64'h0,    0, 0, 0, 0, 0, 0, 64'h0,  4'd0, 8'd0);

      for (int i = 0; i < 256; i++) begin
         c_before = 8'(i);
         c_after  = (i == 255) ? 8'd255 : 8'(i + 1);
         elr_prev = (i == 0) ? 64'h0 : 64'h100;
         esr_prev = (i == 0) ? 4'd0 : 4'd3;
         step("sat_fault", 0, 4'd3, 0, 0, 64'h100, 1, 0, 1, 0, 0, 0, elr_prev, esr_prev,
              c_before);
         step("sat_eret",  0, 4'd0, 1, 0, 64'hD8,  0, 1, 0, 0, 1, 0, 64'h100, 4'd3, c_after);
      end
      step("sat_final",      0, 4'd0, 0, 0, 64'h100,  0, 0, 0, 0, 0, 0, 64'h100, 4'd3, 8'd255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Exception sequencer for the single-cycle LEGv8 core. Sits beside the main decoder and the PC logic. It takes the decoder's `EStatus`/`ERet` outputs plus an external interrupt line, and decides when control transfers to the handler vector or back to the saved PC. It holds the ELR/ESR state read by MRS and suppresses architectural writes of the faulting instruction.

## Interface
- `N`, 64: datapath/PC width.
- `VECTOR`, 64'hD8: handler entry address driven on `ExcVector`.
- `IRQ_CODE`, 4'b0001: ESR value recorded for an external interrupt.
- `ERET_CODE`, 4'b0100: ESR value recorded for ERET executed outside exception mode.
- `clk` in 1: core clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `EStatus` in 4: decoder status for the current instruction; nonzero means a synchronous exception.
- `ERet` in 1: decoder flag, current instruction is ERET.
- `ExtIRQ` in 1: level-sensitive external interrupt request.
- `PC` in N: address of the instruction executing this cycle.
- `Exc` out 1: redirect next PC to `ExcVector` (combinational).
- `ExcVector` out N: constant `VECTOR`.
- `ERetTaken` out 1: redirect next PC to `ELR` (combinational).
- `KillWB` out 1: suppress RegWrite/MemWrite/MemRead of the current instruction (combinational).
- `ExtIAck` out 1: registered one-cycle acknowledge of an accepted IRQ.
- `ELR` out N: saved return PC, registered.
- `ESR` out 4: saved cause code, registered.
- `ExcMode` out 1: high while in HANDLER, registered.
- `Halt` out 1: high in LOCKUP, registered.
- `ExcCount` out 8: saturating count of exceptions taken, registered.

## Operation
States:
- **RUN**: normal execution; accepts exceptions.
- **HANDLER**: handler executing; IRQ masked.
- **LOCKUP**: fatal; only `reset` leaves it.

Additional state: a 1-bit `shadow` flag.

Events in RUN, in priority order:
1. Sync exception: `EStatus != 0`, or `ERet=1`.
   - Cause code = `EStatus`, or `ERET_CODE` when `EStatus = 0` and `ERet = 1`.
2. IRQ: `ExtIRQ=1` and `shadow=0`.

On any RUN event:
- Combinationally: `Exc=1`, `KillWB=1`.
- On the clock edge: `ELR<=PC`, `ESR<=cause` (`IRQ_CODE` for IRQ), `ExcCount<=ExcCount+1` (saturating at 255), state goes to HANDLER.
- For IRQ only: `ExtIAck` goes high for the following cycle.
- The killed instruction is re-executed on return, because ELR holds its own PC.
- A sync exception and IRQ in the same cycle: the sync exception wins. IRQ stays pending (level) and no `ExtIAck` is generated.

In HANDLER:
- `ERet=1` with `EStatus=0`: `ERetTaken=1`, `KillWB=0`. Next state RUN, `shadow<=1`.
- `EStatus != 0`: nested fault. `KillWB=1`, `Exc=0`, `ERetTaken=0`. Next state LOCKUP. ELR/ESR keep the original fault; `ExcCount` still increments.
- `ExtIRQ` is ignored; no ack.
- Otherwise stay in HANDLER; ELR/ESR hold.

Shadow rule:
- `shadow` clears after exactly one instruction completes in RUN.
- While `shadow=1`, IRQ is blocked but sync exceptions are taken normally. This guarantees forward progress under a stuck-high `ExtIRQ`.

In LOCKUP:
- `Halt=1`, `KillWB=1`, `Exc=0`, `ERetTaken=0`; all inputs ignored.

`Exc`, `ERetTaken` and `KillWB` are mutually exclusive except `KillWB` with `Exc`.

## Timing
- Reset (synchronous) values: state RUN, `ELR=0`, `ESR=0`, `ExcMode=0`, `Halt=0`, `ExcCount=0`, `shadow=0`, `ExtIAck=0`.
- Combinational outputs are 0 in the reset cycle.
- `reset` has priority over every event. An exception presented in the same cycle as `reset` is discarded: no ELR/ESR update.
- Exception latency: redirect is visible the same cycle as the faulting instruction. The PC loads `VECTOR` at the next edge; `ExcMode` rises at that edge.
- ERET latency: PC loads `ELR` at the next edge; `ExcMode` falls at that edge.
- `ExtIAck` is high exactly one cycle, the cycle after acceptance.
- `ELR` and `ESR` are stable throughout HANDLER, so MRS reads are valid from the first handler instruction.

## Test plan
- Reset, then `EStatus=4'b0010` at `PC=0x40` -> same cycle `Exc=1`, `KillWB=1`. Next cycle `ELR=0x40`, `ESR=0010`, `ExcMode=1`, `ExcCount=1`.
- In HANDLER, `ERet=1` -> `ERetTaken=1`. Next cycle `ExcMode=0`. `ExtIRQ` held high is not taken for one instruction, then taken: `ESR=0001`, `ExtIAck` pulses one cycle.
- `EStatus=0010` and `ExtIRQ=1` in the same RUN cycle -> `ESR=0010`, no `ExtIAck`. After ERET plus the one-instruction shadow, IRQ is taken.
- `ERet=1` in RUN at `PC=0x80` -> `Exc=1`. Next cycle `ESR=0100`, `ELR=0x80`.
- `EStatus=0010` in HANDLER -> LOCKUP with `Halt=1`, ELR/ESR unchanged. `reset=1` for one cycle -> all outputs return to reset values.
- 256 exceptions with an ERET after each -> `ExcCount` saturates at 255.
